// File: rtl/calc_pkg.sv
// Shared constants for the stream calculator front end: opcodes, error codes,
// ASCII characters recognised by the command parser, and the parser state type.
package calc_pkg;

   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_SUB  = 3'd1;
   localparam logic [2:0] OP_MUL  = 3'd2;
   localparam logic [2:0] OP_DIV  = 3'd3;
   localparam logic [2:0] OP_FDIV = 3'd4;
   localparam logic [2:0] OP_PUSH = 3'd5;
   localparam logic [2:0] OP_POP  = 3'd6;
   localparam logic [2:0] OP_BAD  = 3'd7;

   localparam logic [1:0] ERR_OVF  = 2'd1;
   localparam logic [1:0] ERR_CHAR = 2'd2;

   localparam logic [7:0] CH_0     = 8'h30;
   localparam logic [7:0] CH_9     = 8'h39;
   localparam logic [7:0] CH_SPACE = 8'h20;
   localparam logic [7:0] CH_LF    = 8'h0A;
   localparam logic [7:0] CH_CR    = 8'h0D;
   localparam logic [7:0] CH_PLUS  = 8'h2B;
   localparam logic [7:0] CH_MINUS = 8'h2D;
   localparam logic [7:0] CH_STAR  = 8'h2A;
   localparam logic [7:0] CH_SLASH = 8'h2F;
   localparam logic [7:0] CH_COLON = 8'h3A;
   localparam logic [7:0] CH_P     = 8'h70;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_NUM    = 2'd1,
      ST_OPPEND = 2'd2
   } state_e;

endpackage

// File: rtl/calc_char_class.sv
// Combinational ASCII classifier: splits a character into digit / separator /
// operator / illegal, with the digit value and calculator opcode decoded.
module calc_char_class
   import calc_pkg::*;
(
   input  logic [7:0] ch,
   output logic       is_digit,
   output logic [3:0] digit,
   output logic       is_sep,
   output logic       is_op,
   output logic [2:0] opcode,
   output logic       is_bad
);

   always_comb begin
      is_digit = (ch >= CH_0) && (ch <= CH_9);
      // ASCII '0'..'9' are 0x30..0x39, so the low nibble is the digit value
      digit    = is_digit ? ch[3:0] : 4'd0;
      is_sep   = (ch == CH_SPACE) || (ch == CH_LF) || (ch == CH_CR);

      is_op  = 1'b1;
      opcode = OP_BAD;
      case (ch)
         CH_PLUS:  opcode = OP_ADD;
         CH_MINUS: opcode = OP_SUB;
         CH_STAR:  opcode = OP_MUL;
         CH_SLASH: opcode = OP_DIV;
         CH_COLON: opcode = OP_FDIV;
         CH_P:     opcode = OP_POP;
         default:  is_op  = 1'b0;
      endcase

      is_bad = ~(is_digit | is_sep | is_op);
   end

endmodule

// File: rtl/calc_cmd_parser.sv
// ASCII command parser for the stream calculator: accumulates decimal literals
// into pushes, maps operator characters to opcodes, and flags malformed input.
module calc_cmd_parser
   import calc_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int OP_W   = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ch_valid,
   input  logic [7:0]        ch,
   output logic              ch_ready,
   output logic              apply,
   output logic [DATA_W-1:0] val,
   output logic [OP_W-1:0]   op,
   output logic              err,
   output logic [1:0]        err_code
);

   state_e              state_q, state_d;
   logic [DATA_W-1:0]   acc_q, acc_d;
   logic                ovf_q, ovf_d;
   logic [2:0]          pend_op_q, pend_op_d;

   logic                apply_q, apply_d;
   logic [DATA_W-1:0]   val_q, val_d;
   logic [OP_W-1:0]     op_q, op_d;
   logic                err_q, err_d;
   logic [1:0]          err_code_q, err_code_d;

   logic                is_digit, is_sep, is_op, is_bad;
   logic [3:0]          digit;
   logic [2:0]          opcode;
   logic                accept;
   logic                in_num;
   logic [DATA_W+3:0]   acc_mul;
   logic                acc_ovf;

   calc_char_class u_class (
      .ch       (ch),
      .is_digit (is_digit),
      .digit    (digit),
      .is_sep   (is_sep),
      .is_op    (is_op),
      .opcode   (opcode),
      .is_bad   (is_bad)
   );

   assign ch_ready = (state_q != ST_OPPEND);
   assign accept   = ch_valid & ch_ready;
   assign in_num   = (state_q == ST_NUM);

   // acc*10 + d with four guard bits; anything above the top DATA_W bits is overflow
   assign acc_mul = ({4'd0, acc_q} << 3) + ({4'd0, acc_q} << 1)
                  + {{DATA_W{1'b0}}, digit};
   assign acc_ovf = |acc_mul[DATA_W+3:DATA_W];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         acc_q      <= '0;
         ovf_q      <= 1'b0;
         pend_op_q  <= OP_ADD;
         apply_q    <= 1'b0;
         val_q      <= '0;
         op_q       <= '0;
         err_q      <= 1'b0;
         err_code_q <= '0;
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         ovf_q      <= ovf_d;
         pend_op_q  <= pend_op_d;
         apply_q    <= apply_d;
         val_q      <= val_d;
         op_q       <= op_d;
         err_q      <= err_d;
         err_code_q <= err_code_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      ovf_d     = ovf_q;
      pend_op_d = pend_op_q;
      case (state_q)
         ST_OPPEND: state_d = ST_IDLE;
         default: begin
            if (accept) begin
               if (is_digit) begin
                  acc_d   = acc_mul[DATA_W-1:0];
                  ovf_d   = ovf_q | acc_ovf;
                  state_d = ST_NUM;
               end else begin
                  // separators, operators and illegal characters all end a literal
                  acc_d   = '0;
                  ovf_d   = 1'b0;
                  state_d = ST_IDLE;
                  if (is_op && in_num && !ovf_q) begin
                     state_d   = ST_OPPEND;
                     pend_op_d = opcode;
                  end
               end
            end
         end
      endcase
   end

   always_comb begin
      apply_d    = 1'b0;
      err_d      = 1'b0;
      val_d      = val_q;
      op_d       = op_q;
      err_code_d = err_code_q;
      if (state_q == ST_OPPEND) begin
         apply_d = 1'b1;
         op_d    = OP_W'(pend_op_q);
         val_d   = '0;
      end else if (accept) begin
         if (is_bad) begin
            err_d      = 1'b1;
            err_code_d = ERR_CHAR;
         end else if ((is_sep || is_op) && in_num) begin
            if (ovf_q) begin
               err_d      = 1'b1;
               err_code_d = ERR_OVF;
            end else begin
               apply_d = 1'b1;
               op_d    = OP_W'(OP_PUSH);
               val_d   = acc_q;
            end
         end else if (is_op) begin
            apply_d = 1'b1;
            op_d    = OP_W'(opcode);
            val_d   = '0;
         end
      end
   end

   assign apply    = apply_q;
   assign val      = val_q;
   assign op       = op_q;
   assign err      = err_q;
   assign err_code = err_code_q;

endmodule
